// File: rtl/io_issue_controller.sv
// Memory-stage I/O sequencer: buffers output bytes toward UART TX and
// stalls input ops until a UART RX byte is available for write-back.
module io_issue_controller #(
   parameter int OUT_DEPTH = 4,
   parameter int DATA_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              out_issued,
   input  logic [DATA_W-1:0] out_data,
   input  logic              in_issued,
   output logic [DATA_W-1:0] in_data,
   output logic              in_valid,
   output logic              stall,
   output logic              tx_valid,
   output logic [DATA_W-1:0] tx_data,
   input  logic              tx_ready,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] rx_data,
   output logic              rx_ready
);

   localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(OUT_DEPTH);

   typedef enum logic [1:0] {
      IN_IDLE,
      IN_WAIT,
      IN_DONE
   } in_state_t;

   logic [DATA_W-1:0] mem [OUT_DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              push;
   logic              pop;
   logic              out_stall;
   logic              in_stall;
   logic [DATA_W-1:0] in_data_q;
   in_state_t         state;
   in_state_t         state_nxt;

   // Full check uses the registered count; a same-cycle pop does not
   // let the blocked store in, it retries next cycle.
   assign full      = (count == FULL);
   assign tx_valid  = (count != '0);
   assign tx_data   = mem[rd_ptr];
   assign pop       = tx_valid && tx_ready;
   assign push      = out_issued && !full;
   assign out_stall = out_issued && full;

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr] <= out_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IN_IDLE;
         in_data_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == IN_WAIT && rx_valid) begin
            in_data_q <= rx_data;
         end
      end
   end

   // in_issued seen in IN_DONE is the completing op itself, not a new one
   always_comb begin
      state_nxt = state;
      in_stall  = 1'b0;
      rx_ready  = 1'b0;
      in_valid  = 1'b0;
      case (state)
         IN_IDLE: begin
            if (in_issued) begin
               in_stall  = 1'b1;
               state_nxt = IN_WAIT;
            end
         end
         IN_WAIT: begin
            in_stall = 1'b1;
            rx_ready = 1'b1;
            if (rx_valid) begin
               state_nxt = IN_DONE;
            end
         end
         IN_DONE: begin
            in_valid  = 1'b1;
            state_nxt = IN_IDLE;
         end
         default: begin
            state_nxt = IN_IDLE;
         end
      endcase
   end

   assign in_data = in_data_q;
   assign stall   = out_stall | in_stall;

endmodule
